// File: rtl/tower_placer_grid.sv
// Grid cursor + tower placer for the VGA playfield; paints its own tiles one pixel per granted clock.
// Build option TP_SELL_EN: placing on an occupied cell sells (clears) the tower instead of rejecting.
module tower_placer_grid #(
  parameter int TILE = 16,
  parameter int COLS = 10,
  parameter int ROWS = 7,
  parameter logic [8:0] CUR_COL = 9'h1F8,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          go_up,
  input  logic          go_down,
  input  logic          go_left,
  input  logic          go_right,
  input  logic          go_place,
  input  logic [1:0]    tower_type,
  input  logic          enable_draw,
  output logic          vga_WriteEn,
  output logic [14:0]   vga_coords,
  output logic [8:0]    vga_colour,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic          busy,
  output logic          place_done,
  output logic          place_reject
);
  // state       | meaning
  // S_IDLE      | waiting for a key event
  // S_ERASE     | repaint old cursor cell with its content colour
  // S_MOVE      | commit target cursor position
  // S_DRAW_CUR  | paint cursor border + content interior
  // S_PLACE_CHK | test occupancy, update maps
  // S_DONE      | report placement, back to idle
  localparam int PW    = $clog2(TILE);
  localparam int NCELL = COLS * ROWS;
  localparam int IW    = $clog2(NCELL);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_MOVE, S_DRAW_CUR, S_PLACE_CHK, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic             live;
  logic [4:0]       key_q, key_now, key_rise;
  logic             move_ok;
  logic [CW-1:0]    nxt_col, tgt_col;
  logic [RW-1:0]    nxt_row, tgt_row;
  logic [PW-1:0]    px, py;
  logic [NCELL-1:0] occ;
  logic [1:0]       typ_map [NCELL];
  logic [1:0]       type_q;
  logic             placing;
  logic [IW-1:0]    idx;
  logic [8:0]       content;
  logic             scan_en, scan_last, border;
  logic [7:0]       x_pix;
  logic [6:0]       y_pix;

  function automatic logic [8:0] type_colour(input logic [1:0] t);
    case (t)
      2'd0:    return 9'h1C0;
      2'd1:    return 9'h038;
      2'd2:    return 9'h007;
      default: return 9'h1FF;
    endcase
  endfunction

  assign key_now   = {go_place, go_up, go_down, go_left, go_right};
  assign key_rise  = key_now & ~key_q;
  assign idx       = IW'(cursor_row) * IW'(COLS) + IW'(cursor_col);
  assign content   = occ[idx] ? type_colour(typ_map[idx]) : 9'h000;
  // live holds off scanning for the first clock after reset so the tile starts cleanly at pixel 0
  assign scan_en   = live && enable_draw && (state == S_ERASE || state == S_DRAW_CUR);
  assign scan_last = scan_en && (&px) && (&py);
  assign border    = (px == '0) || (&px) || (py == '0) || (&py);
  assign x_pix     = 8'(cursor_col) * 8'(TILE) + 8'(px);
  assign y_pix     = 7'(cursor_row) * 7'(TILE) + 7'(py);

  // Highest-priority direction wins; an off-grid target is simply not a valid move.
  always_comb begin
    move_ok = 1'b0;
    nxt_col = cursor_col;
    nxt_row = cursor_row;
    if (key_rise[3]) begin
      move_ok = (cursor_row != '0);
      nxt_row = cursor_row - 1'b1;
    end else if (key_rise[2]) begin
      move_ok = (cursor_row != RW'(ROWS - 1));
      nxt_row = cursor_row + 1'b1;
    end else if (key_rise[1]) begin
      move_ok = (cursor_col != '0);
      nxt_col = cursor_col - 1'b1;
    end else if (key_rise[0]) begin
      move_ok = (cursor_col != CW'(COLS - 1));
      nxt_col = cursor_col + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_DRAW_CUR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (key_rise[4])  state_nxt = S_PLACE_CHK;
        else if (move_ok) state_nxt = S_ERASE;
      end
      S_ERASE:    if (scan_last) state_nxt = S_MOVE;
      S_MOVE:     state_nxt = S_DRAW_CUR;
      S_DRAW_CUR: if (scan_last) state_nxt = S_DONE;
      S_PLACE_CHK: begin
`ifdef TP_SELL_EN
        state_nxt = S_DRAW_CUR;
`else
        state_nxt = occ[idx] ? S_IDLE : S_DRAW_CUR;
`endif
      end
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live         <= 1'b0;
      key_q        <= '0;
      cursor_col   <= '0;
      cursor_row   <= '0;
      tgt_col      <= '0;
      tgt_row      <= '0;
      px           <= '0;
      py           <= '0;
      occ          <= '0;
      for (int i = 0; i < NCELL; i++) typ_map[i] <= 2'd0;
      type_q       <= 2'd0;
      placing      <= 1'b0;
      place_done   <= 1'b0;
      place_reject <= 1'b0;
    end else begin
      live         <= 1'b1;
      key_q        <= key_now;
      place_done   <= 1'b0;
      place_reject <= 1'b0;
      if (scan_en) begin
        px <= px + 1'b1;
        if (&px) py <= py + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (key_rise[4]) type_q <= tower_type;
          else if (move_ok) begin
            tgt_col <= nxt_col;
            tgt_row <= nxt_row;
          end
        end
        S_MOVE: begin
          cursor_col <= tgt_col;
          cursor_row <= tgt_row;
        end
        S_PLACE_CHK: begin
          if (!occ[idx]) begin
            occ[idx]     <= 1'b1;
            typ_map[idx] <= type_q;
            placing      <= 1'b1;
          end else begin
`ifdef TP_SELL_EN
            occ[idx] <= 1'b0;
            placing  <= 1'b1;
`else
            place_reject <= 1'b1;
`endif
          end
        end
        S_DONE: begin
          place_done <= placing;
          placing    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    vga_WriteEn = scan_en;
    vga_coords  = '0;
    vga_colour  = '0;
    busy        = resetn && (state != S_IDLE);
    if (scan_en) begin
      vga_coords = {x_pix, y_pix};
      vga_colour = (state == S_DRAW_CUR && border) ? CUR_COL : content;
    end
  end
endmodule

// File: tb/tb_tower_placer_grid.sv
// Bench for tower_placer_grid: directed scenarios plus random key sequences against a cell/colour model.
// Honours TP_SELL_EN the same way the design does.
module tb_tower_placer_grid;
  localparam int TILE = 16;
  localparam int COLS = 10;
  localparam int ROWS = 7;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go_up, go_down, go_left, go_right, go_place;
  logic [1:0] tower_type;
  logic       enable_draw;
  logic       vga_WriteEn;
  logic [14:0] vga_coords;
  logic [8:0] vga_colour;
  logic [3:0] cursor_col;
  logic [2:0] cursor_row;
  logic       busy, place_done, place_reject;

  tower_placer_grid dut (
    .clk(clk), .resetn(resetn),
    .go_up(go_up), .go_down(go_down), .go_left(go_left), .go_right(go_right),
    .go_place(go_place), .tower_type(tower_type), .enable_draw(enable_draw),
    .vga_WriteEn(vga_WriteEn), .vga_coords(vga_coords), .vga_colour(vga_colour),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy),
    .place_done(place_done), .place_reject(place_reject)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model of the playfield
  int         m_col, m_row;
  bit         m_occ [COLS*ROWS];
  logic [1:0] m_typ [COLS*ROWS];
  int         exp_x[$], exp_y[$];
  logic [8:0] exp_c[$];
  int         exp_done, exp_rej, exp_busy;

  int         cap_x[$], cap_y[$];
  logic [8:0] cap_c[$];
  int         done_n, rej_n, busy_n, stall_w, bad_en, timed_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] pal(input logic [1:0] t);
    case (t)
      2'd0:    return 9'h1C0;
      2'd1:    return 9'h038;
      2'd2:    return 9'h007;
      default: return 9'h1FF;
    endcase
  endfunction

  function automatic logic [8:0] content_of(input int c, input int r);
    int i = r * COLS + c;
    return m_occ[i] ? pal(m_typ[i]) : 9'h000;
  endfunction

  task automatic paint(input int c, input int r, input bit cur);
    logic [8:0] fill = content_of(c, r);
    for (int py = 0; py < TILE; py++)
      for (int px = 0; px < TILE; px++) begin
        exp_x.push_back(c * TILE + px);
        exp_y.push_back(r * TILE + py);
        if (cur && (px == 0 || py == 0 || px == TILE-1 || py == TILE-1)) exp_c.push_back(9'h1F8);
        else exp_c.push_back(fill);
      end
  endtask

  task automatic clear_exp();
    exp_x.delete(); exp_y.delete(); exp_c.delete();
    exp_done = 0; exp_rej = 0; exp_busy = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < COLS*ROWS; i++) begin m_occ[i] = 0; m_typ[i] = 2'd0; end
    m_col = 0; m_row = 0;
    clear_exp();
    paint(0, 0, 1);
    exp_busy = 2 + TILE*TILE;
  endtask

  // k = {place, up, down, left, right}
  task automatic model_op(input bit [4:0] k, input logic [1:0] t);
    int i, dc, dr, nc, nr;
    clear_exp();
    dc = 0; dr = 0;
    if (k[4]) begin
      i = m_row * COLS + m_col;
      if (m_occ[i]) begin
`ifdef TP_SELL_EN
        m_occ[i] = 0;
        paint(m_col, m_row, 1);
        exp_done = 1;
        exp_busy = 2 + TILE*TILE;
`else
        exp_rej  = 1;
        exp_busy = 1;
`endif
      end else begin
        m_occ[i] = 1;
        m_typ[i] = t;
        paint(m_col, m_row, 1);
        exp_done = 1;
        exp_busy = 2 + TILE*TILE;
      end
    end else begin
      if (k[3])      dr = -1;
      else if (k[2]) dr = 1;
      else if (k[1]) dc = -1;
      else if (k[0]) dc = 1;
      nc = m_col + dc;
      nr = m_row + dr;
      if ((dc != 0 || dr != 0) && nc >= 0 && nc < COLS && nr >= 0 && nr < ROWS) begin
        paint(m_col, m_row, 0);
        m_col = nc; m_row = nr;
        paint(m_col, m_row, 1);
        exp_busy = 2 + 2*TILE*TILE;
      end
    end
  endtask

  // Capture until the DUT returns to idle (or never leaves it); inputs change #1 after posedge.
  task automatic run_wait(input int stall_at, input bit rnd_en);
    int  cyc = 0, post = -1, stall_left = 20;
    bit  seen = 0, stalling = 0;
    cap_x.delete(); cap_y.delete(); cap_c.delete();
    done_n = 0; rej_n = 0; busy_n = 0; stall_w = 0; bad_en = 0; timed_out = 0;
    while (1) begin
      @(negedge clk);
      if (vga_WriteEn) begin
        if (!enable_draw) bad_en++;
        if (stalling) stall_w++;
        cap_x.push_back(int'(vga_coords[14:7]));
        cap_y.push_back(int'(vga_coords[6:0]));
        cap_c.push_back(vga_colour);
      end
      if (busy) begin busy_n++; seen = 1; end
      if (place_done) done_n++;
      if (place_reject) rej_n++;
      if (post >= 0) post++;
      else if (seen && !busy) post = 0;
      if (post >= 3) break;
      if (!seen && cyc >= 6) break;
      if (cyc >= 6000) begin timed_out = 1; break; end
      cyc++;
      @(posedge clk); #1;
      {go_place, go_up, go_down, go_left, go_right} = 5'b0;
      stalling = 0;
      if (stall_at >= 0 && cap_x.size() == stall_at && stall_left > 0) begin
        enable_draw = 1'b0;
        stall_left--;
        stalling = 1;
      end else if (rnd_en) enable_draw = ($urandom_range(0, 3) != 0);
      else enable_draw = 1'b1;
    end
    enable_draw = 1'b1;
  endtask

  task automatic check_op(input string tag, input bit chk_busy);
    int mism = 0, n;
    n = (cap_x.size() < exp_x.size()) ? cap_x.size() : exp_x.size();
    for (int i = 0; i < n; i++)
      if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] !== exp_c[i]) mism++;
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_nwrites"}, cap_x.size(), exp_x.size());
    chk({tag, "_pixels"}, mism, 0);
    chk({tag, "_done"}, done_n, exp_done);
    chk({tag, "_reject"}, rej_n, exp_rej);
    if (chk_busy) chk({tag, "_busy_cycles"}, busy_n, exp_busy);
    chk({tag, "_col"}, 32'(cursor_col), m_col);
    chk({tag, "_row"}, 32'(cursor_row), m_row);
    chk({tag, "_we_gated"}, bad_en, 0);
  endtask

  task automatic do_op(input bit [4:0] k, input logic [1:0] t, input int stall_at,
                       input bit rnd_en, input string tag);
    model_op(k, t);
    @(posedge clk); #1;
    {go_place, go_up, go_down, go_left, go_right} = k;
    tower_type = t;
    run_wait(stall_at, rnd_en);
    check_op(tag, !rnd_en && stall_at < 0);
  endtask

  localparam bit [4:0] K_PLACE = 5'b10000, K_UP = 5'b01000, K_DOWN = 5'b00100,
                       K_LEFT = 5'b00010, K_RIGHT = 5'b00001;

  initial begin
    bit [4:0] k;
    resetn = 1'b0;
    {go_place, go_up, go_down, go_left, go_right} = 5'b0;
    tower_type  = 2'd0;
    enable_draw = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", vga_WriteEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_col", 32'(cursor_col), 0);
    chk("rst_row", 32'(cursor_row), 0);
    chk("rst_pulses", {place_done, place_reject}, 0);
    chk("rst_coords_colour", {vga_coords, vga_colour}, 0);

    // initial cursor paint: 1 wake cycle + 256 pixels + DONE
    model_reset();
    @(posedge clk); #1 resetn = 1'b1;
    run_wait(-1, 0);
    check_op("reset", 1);

    do_op(K_RIGHT, 2'd0, -1, 0, "right");
    for (int i = 0; i < 8; i++) do_op(K_RIGHT, 2'd0, -1, 0, "to_col9");
    do_op(K_RIGHT, 2'd0, -1, 0, "clamp_right");
    do_op(K_UP, 2'd0, -1, 0, "clamp_up");
    for (int i = 0; i < 7; i++) do_op(K_LEFT, 2'd0, -1, 0, "to_col2");
    for (int i = 0; i < 3; i++) do_op(K_DOWN, 2'd0, -1, 0, "to_row3");

    do_op(K_PLACE, 2'd1, -1, 0, "place");
    chk("place_first_interior", {cap_x[17], cap_y[17], 23'(cap_c[17])}, {32'd33, 32'd49, 23'h038});
    chk("place_last_interior", {cap_x[238], cap_y[238], 23'(cap_c[238])}, {32'd46, 32'd62, 23'h038});
    do_op(K_PLACE, 2'd1, -1, 0, "place_again");

    // 20-cycle grant drop once 100 pixels of the erase scan are out
    do_op(K_LEFT, 2'd0, 100, 0, "stall");
    chk("stall_writes", stall_w, 0);
    chk("stall_total", cap_x.size(), 2*TILE*TILE);

    // reset in the middle of an erase scan
    @(posedge clk); #1 go_down = 1'b1;
    @(posedge clk); #1 go_down = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_erase_active", vga_WriteEn, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_we", vga_WriteEn, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cursor", {28'(cursor_col), 4'(cursor_row)}, 0);
    model_reset();
    @(posedge clk); #1 resetn = 1'b1;
    run_wait(-1, 0);
    check_op("rst_mid", 1);

    // cell (2,3) was occupied before reset; it must accept a placement now
    do_op(K_RIGHT, 2'd0, -1, 0, "back");
    do_op(K_RIGHT, 2'd0, -1, 0, "back");
    for (int i = 0; i < 3; i++) do_op(K_DOWN, 2'd0, -1, 0, "back");
    do_op(K_PLACE, 2'd3, -1, 0, "place_after_rst");
    chk("place_after_rst_pulse", done_n, 1);

    do_op(K_RIGHT, 2'd0, -1, 0, "to_col3");
    do_op(K_UP | K_PLACE, 2'd2, -1, 0, "up_place");
    chk("up_place_row", 32'(cursor_row), 3);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    k = K_PLACE;
        2, 3:    k = K_UP;
        4, 5:    k = K_DOWN;
        6, 7:    k = K_LEFT;
        default: k = K_RIGHT;
      endcase
      if ($urandom_range(0, 4) == 0) k = k | 5'(1 << $urandom_range(0, 4));
      do_op(k, 2'($urandom_range(0, 3)), -1, 1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
